// File: rtl/gci_std_display_write_arbiter.sv
// rtl/gci_std_display_write_arbiter.sv - display memory write port shared by bus writes and a bitmap fill engine
module gci_std_display_write_arbiter #(
    parameter logic [31:0] CLEAR_WADDR    = 32'h0000_3000,
    parameter logic [31:0] BMP_BASE_WADDR = 32'h0000_3100,
    parameter int unsigned BMP_WORDS      = 307200,
    parameter int unsigned FILL_BURST     = 16
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iBUS_REQ,
    output logic        oBUS_BUSY,
    input  logic [31:0] iBUS_ADDR,
    input  logic [31:0] iBUS_DATA,
    output logic        oIF_WR_REQ,
    input  logic        iIF_WR_BUSY,
    output logic [31:0] oIF_WR_ADDR,
    output logic [31:0] oIF_WR_DATA,
    output logic        oFILL_BUSY,
    output logic        oFILL_DONE
);

    // Index carries one spare bit so "all words loaded" is simply idx == BMP_WORDS.
    localparam int unsigned IDXW = $clog2(BMP_WORDS) + 1;
    localparam int unsigned BW   = $clog2(FILL_BURST + 1);

    localparam logic [IDXW-1:0] IDX_END   = IDXW'(BMP_WORDS);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(BMP_WORDS - 1);
    localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(FILL_BURST);
    localparam logic [BW-1:0]   BURST_ONE = BW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [BW-1:0]   burst_q;
    logic [15:0]     colour_q;
    logic            req_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic            last_q;
    logic            fill_done_q;

    logic slot_free;
    logic bus_grant;
    logic bus_acc;
    logic clear_acc;
    logic bus_load;
    logic fill_load;
    logic fill_done_d;

    // Upper half of a clear command's data carries no meaning.
    logic unused_bus_data_hi;
    assign unused_bus_data_hi = ^iBUS_DATA[31:16];

    // Grant and load decisions; the bus grant follows iIF_WR_BUSY combinationally.
    always_comb begin
        slot_free   = !req_q || !iIF_WR_BUSY;
        bus_grant   = slot_free && ((state_q == ST_IDLE) || (burst_q == BURST_MAX));
        bus_acc     = iBUS_REQ && bus_grant;
        clear_acc   = bus_acc && (iBUS_ADDR == CLEAR_WADDR);
        bus_load    = bus_acc && !clear_acc;
        fill_load   = (state_q == ST_FILL) && slot_free && !bus_acc && (idx_q != IDX_END);
        // A clear taken in the same cycle aborts the fill, so no done pulse for it.
        fill_done_d = (state_q == ST_FILL) && last_q && req_q && !iIF_WR_BUSY && !clear_acc;
    end

    assign oBUS_BUSY   = !bus_grant;
    assign oIF_WR_REQ  = req_q;
    assign oIF_WR_ADDR = addr_q;
    assign oIF_WR_DATA = data_q;
    assign oFILL_BUSY  = (state_q == ST_FILL);
    assign oFILL_DONE  = fill_done_q;

    // Output slot, fill sequencing and IDLE/FILL state machine.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            burst_q     <= '0;
            colour_q    <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= fill_done_d;

            if (slot_free) begin
                if (bus_load) begin
                    req_q  <= 1'b1;
                    addr_q <= iBUS_ADDR;
                    data_q <= iBUS_DATA;
                    last_q <= 1'b0;
                end else if (fill_load) begin
                    req_q  <= 1'b1;
                    addr_q <= BMP_BASE_WADDR + 32'(idx_q);
                    data_q <= {16'h0000, colour_q};
                    last_q <= (idx_q == IDX_LAST);
                end else begin
                    req_q  <= 1'b0;
                    last_q <= 1'b0;
                end
            end

            if (fill_load) begin
                idx_q <= idx_q + IDX_ONE;
                if (burst_q != BURST_MAX) begin
                    burst_q <= burst_q + BURST_ONE;
                end
            end

            // A bus write taken at a fairness slot opens a fresh burst window.
            if (bus_load && (state_q == ST_FILL)) begin
                burst_q <= '0;
            end

            if (fill_done_d) begin
                state_q <= ST_IDLE;
            end

            if (clear_acc) begin
                state_q  <= ST_FILL;
                colour_q <= iBUS_DATA[15:0];
                idx_q    <= '0;
                burst_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gci_std_display_write_arbiter.sv
// tb/tb_gci_std_display_write_arbiter.sv - scoreboard bench for the display write arbiter
module tb_gci_std_display_write_arbiter;

    localparam logic [31:0] CLR  = 32'h0000_3000;
    localparam logic [31:0] BASE = 32'h0000_3100;
    localparam int NW = 12;
    localparam int FB = 4;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iBUS_REQ = 1'b0;
    logic        oBUS_BUSY;
    logic [31:0] iBUS_ADDR = '0;
    logic [31:0] iBUS_DATA = '0;
    logic        oIF_WR_REQ;
    logic        iIF_WR_BUSY = 1'b0;
    logic [31:0] oIF_WR_ADDR;
    logic [31:0] oIF_WR_DATA;
    logic        oFILL_BUSY;
    logic        oFILL_DONE;

    gci_std_display_write_arbiter #(
        .CLEAR_WADDR    (CLR),
        .BMP_BASE_WADDR (BASE),
        .BMP_WORDS      (NW),
        .FILL_BURST     (FB)
    ) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iBUS_REQ    (iBUS_REQ),
        .oBUS_BUSY   (oBUS_BUSY),
        .iBUS_ADDR   (iBUS_ADDR),
        .iBUS_DATA   (iBUS_DATA),
        .oIF_WR_REQ  (oIF_WR_REQ),
        .iIF_WR_BUSY (iIF_WR_BUSY),
        .oIF_WR_ADDR (oIF_WR_ADDR),
        .oIF_WR_DATA (oIF_WR_DATA),
        .oFILL_BUSY  (oFILL_BUSY),
        .oFILL_DONE  (oFILL_DONE)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  total_cnt = 0;
    int  pass_cnt  = 0;
    int  done_cnt  = 0;

    function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    task automatic push_fill(input logic [15:0] c, input int first, input int n);
        for (int i = first; i < first + n; i++) sb.push_back(mk(BASE + 32'(i), {16'h0000, c}));
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    // Scoreboard: every IF transfer must match the next expected write.
    always @(negedge iCLOCK) begin
        if (inRESET && oFILL_DONE) done_cnt++;
        if (inRESET && oIF_WR_REQ && !iIF_WR_BUSY) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL if_write unexpected: got addr=%h data=%h, required no write", oIF_WR_ADDR, oIF_WR_DATA);
            end else begin
                mon_e = sb.pop_front();
                if (oIF_WR_ADDR !== mon_e.addr || oIF_WR_DATA !== mon_e.data)
                    $display("FAIL if_write order: got addr=%h data=%h, required addr=%h data=%h",
                             oIF_WR_ADDR, oIF_WR_DATA, mon_e.addr, mon_e.data);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        inRESET = 1'b0;
        iBUS_REQ = 1'b0;
        repeat (2) @(negedge iCLOCK);
        total_cnt++;
        if (oIF_WR_REQ !== 1'b0 || oIF_WR_ADDR !== 32'h0 || oIF_WR_DATA !== 32'h0)
            $display("FAIL reset_if: got req=%b addr=%h data=%h, required 0/0/0", oIF_WR_REQ, oIF_WR_ADDR, oIF_WR_DATA);
        else pass_cnt++;
        total_cnt++;
        if (oFILL_BUSY !== 1'b0 || oFILL_DONE !== 1'b0)
            $display("FAIL reset_fill: got busy=%b done=%b, required 0/0", oFILL_BUSY, oFILL_DONE);
        else pass_cnt++;
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL reset_bus_busy: got %b, required 0", oBUS_BUSY);
        else pass_cnt++;
        step();
        inRESET = 1'b1;
    endtask

    task automatic single_write(input logic [31:0] a, input logic [31:0] d, input string nm);
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = a; iBUS_DATA = d;
        @(negedge iCLOCK);
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL %s_accept: got bus_busy=%b, required 0", nm, oBUS_BUSY);
        else pass_cnt++;
        sb.push_back(mk(a, d));
        step();
        iBUS_REQ = 1'b0;
        @(negedge iCLOCK);
        total_cnt++;
        if (oIF_WR_REQ !== 1'b1 || oIF_WR_ADDR !== a || oIF_WR_DATA !== d)
            $display("FAIL %s_latency: got req=%b addr=%h data=%h, required 1 %h %h", nm, oIF_WR_REQ, oIF_WR_ADDR, oIF_WR_DATA, a, d);
        else pass_cnt++;
        step();
        @(negedge iCLOCK);
        total_cnt++;
        if (oIF_WR_REQ !== 1'b0) $display("FAIL %s_one_cycle: got req=%b, required 0", nm, oIF_WR_REQ);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        single_write(32'h0000_0100, 32'hDEAD_BEEF, "single");
    endtask

    task automatic test_stall();
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = 32'h0000_0100; iBUS_DATA = 32'hDEAD_BEEF; iIF_WR_BUSY = 1'b0;
        @(negedge iCLOCK);
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL stall_accept1: got bus_busy=%b, required 0", oBUS_BUSY);
        else pass_cnt++;
        sb.push_back(mk(32'h0000_0100, 32'hDEAD_BEEF));
        step();
        iBUS_ADDR = 32'h0000_0104; iBUS_DATA = 32'h1234_5678; iIF_WR_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                step();
                iIF_WR_BUSY = 1'b0;
            end else if (i > 0) begin
                step();
            end
            @(negedge iCLOCK);
            total_cnt++;
            if (oIF_WR_REQ !== 1'b1 || oIF_WR_ADDR !== 32'h0000_0100 || oIF_WR_DATA !== 32'hDEAD_BEEF)
                $display("FAIL stall_hold%0d: got req=%b addr=%h data=%h, required 1 00000100 deadbeef", i, oIF_WR_REQ, oIF_WR_ADDR, oIF_WR_DATA);
            else pass_cnt++;
            total_cnt++;
            if (oBUS_BUSY !== (i < 3)) $display("FAIL stall_bus_busy%0d: got %b, required %b", i, oBUS_BUSY, (i < 3));
            else pass_cnt++;
        end
        sb.push_back(mk(32'h0000_0104, 32'h1234_5678));
        step();
        iBUS_REQ = 1'b0;
        @(negedge iCLOCK);
        total_cnt++;
        if (oIF_WR_REQ !== 1'b1 || oIF_WR_ADDR !== 32'h0000_0104 || oIF_WR_DATA !== 32'h1234_5678)
            $display("FAIL stall_second: got req=%b addr=%h data=%h, required 1 00000104 12345678", oIF_WR_REQ, oIF_WR_ADDR, oIF_WR_DATA);
        else pass_cnt++;
        step();
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        @(negedge iCLOCK);
        while (!oFILL_DONE && cyc < bound) begin
            step();
            @(negedge iCLOCK);
            cyc++;
        end
    endtask

    task automatic test_fill();
        int cyc;
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = CLR; iBUS_DATA = 32'h0000_F800;
        @(negedge iCLOCK);
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL fill_clear_accept: got bus_busy=%b, required 0", oBUS_BUSY);
        else pass_cnt++;
        push_fill(16'hF800, 0, NW);
        step();
        iBUS_REQ = 1'b0;
        @(negedge iCLOCK);
        total_cnt++;
        if (oFILL_BUSY !== 1'b1 || oIF_WR_REQ !== 1'b0)
            $display("FAIL fill_start: got fill_busy=%b req=%b, required 1 0", oFILL_BUSY, oIF_WR_REQ);
        else pass_cnt++;
        step();
        wait_done(100, cyc);
        // Clear accepted at cycle 0, 12 words transfer on cycles 2..13, done on cycle 14.
        total_cnt++;
        if (cyc + 2 != NW + 2 || oFILL_DONE !== 1'b1)
            $display("FAIL fill_done_time: got done=%b at cycle %0d, required 1 at cycle %0d", oFILL_DONE, cyc + 2, NW + 2);
        else pass_cnt++;
        total_cnt++;
        if (oFILL_BUSY !== 1'b0) $display("FAIL fill_busy_clear: got %b, required 0", oFILL_BUSY);
        else pass_cnt++;
        step();
        @(negedge iCLOCK);
        total_cnt++;
        if (oFILL_DONE !== 1'b0) $display("FAIL fill_done_pulse: got %b, required 0", oFILL_DONE);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL fill_all_written: got %0d pending, required 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        int k;
        int cyc;
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = CLR; iBUS_DATA = 32'h0000_07E0;
        @(negedge iCLOCK);
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL fair_clear_accept: got bus_busy=%b, required 0", oBUS_BUSY);
        else pass_cnt++;
        for (int b = 0; b < 3; b++) begin
            push_fill(16'h07E0, b * FB, FB);
            sb.push_back(mk(32'h0000_0200, 32'hB000_0000 + 32'(b)));
        end
        step();
        iBUS_ADDR = 32'h0000_0200; iBUS_DATA = 32'hB000_0000;
        k = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge iCLOCK);
            total_cnt++;
            if (oBUS_BUSY !== ((c % (FB + 1)) != 0))
                $display("FAIL fair_grant_c%0d: got bus_busy=%b, required %b", c, oBUS_BUSY, ((c % (FB + 1)) != 0));
            else pass_cnt++;
            if (!oBUS_BUSY) k++;
            step();
            iBUS_DATA = 32'hB000_0000 + 32'(k);
            if (k >= 3) iBUS_REQ = 1'b0;
        end
        iBUS_REQ = 1'b0;
        wait_done(50, cyc);
        total_cnt++;
        if (oFILL_DONE !== 1'b1 || cyc != 0) $display("FAIL fair_done: got done=%b after %0d extra cycles, required 1 after 0", oFILL_DONE, cyc);
        else pass_cnt++;
        step();
        @(negedge iCLOCK);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL fair_all_written: got %0d pending, required 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_restart();
        int cyc;
        int d0;
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = CLR; iBUS_DATA = 32'h0000_ABCD;
        @(negedge iCLOCK);
        total_cnt++;
        if (oBUS_BUSY !== 1'b0) $display("FAIL restart_clear1: got bus_busy=%b, required 0", oBUS_BUSY);
        else pass_cnt++;
        push_fill(16'hABCD, 0, FB);
        d0 = done_cnt;
        step();
        iBUS_DATA = 32'h0000_001F;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge iCLOCK);
            cyc++;
            if (!oBUS_BUSY) break;
            step();
        end
        total_cnt++;
        if (cyc != FB + 1) $display("FAIL restart_grant_slot: got cycle %0d, required %0d", cyc, FB + 1);
        else pass_cnt++;
        push_fill(16'h001F, 0, NW);
        step();
        iBUS_REQ = 1'b0;
        wait_done(100, cyc);
        total_cnt++;
        if (oFILL_DONE !== 1'b1) $display("FAIL restart_done_seen: got %b, required 1", oFILL_DONE);
        else pass_cnt++;
        repeat (3) step();
        @(negedge iCLOCK);
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL restart_done_count: got %0d, required 1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL restart_all_written: got %0d pending, required 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        int d0;
        step();
        iBUS_REQ = 1'b1; iBUS_ADDR = CLR; iBUS_DATA = 32'h0000_5555;
        @(negedge iCLOCK);
        push_fill(16'h5555, 0, NW);
        d0 = done_cnt;
        step();
        iBUS_REQ = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(negedge iCLOCK);
            step();
        end
        @(negedge iCLOCK);
        total_cnt++;
        if (oIF_WR_REQ !== 1'b1 || oIF_WR_ADDR !== BASE + 32'd4)
            $display("FAIL rst_fill_progress: got req=%b addr=%h, required 1 %h", oIF_WR_REQ, oIF_WR_ADDR, BASE + 32'd4);
        else pass_cnt++;
        #1;
        inRESET = 1'b0;
        #1;
        total_cnt++;
        if (oIF_WR_REQ !== 1'b0 || oFILL_BUSY !== 1'b0 || oIF_WR_ADDR !== 32'h0)
            $display("FAIL rst_immediate: got req=%b fill_busy=%b addr=%h, required 0 0 0", oIF_WR_REQ, oFILL_BUSY, oIF_WR_ADDR);
        else pass_cnt++;
        sb.delete();
        @(posedge iCLOCK);
        #3;
        inRESET = 1'b1;
        single_write(32'h0000_0180, 32'hCAFE_F00D, "post_rst");
        total_cnt++;
        if (done_cnt != d0) $display("FAIL rst_no_done: got %0d pulses, required 0", done_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall();
        test_fill();
        test_fairness();
        test_restart();
        test_reset_mid_fill();
        step();
        @(negedge iCLOCK);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
